// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised two-read, one-write register file
// Optional zero register, write-first bypass and registered read outputs.
module regfile_param #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  parameter  int REG_OUT  = 0,
  parameter  int BYPASS   = 1,
  localparam int AW       = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  input  logic             re2,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid1,
  output logic             rvalid2
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range;
  logic             wr_legal;
  logic [WIDTH-1:0] rd_val1;
  logic [WIDTH-1:0] rd_val2;

  assign wr_in_range = (int'(waddr) < DEPTH);
  // Gating with rst_n keeps the bypass path quiet while storage is held cleared.
  assign wr_legal    = rst_n && we && wr_in_range && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_legal && (waddr == AW'(i))) begin
          mem_q[i] <= wdata;
        end
      end
    end
  end

  // Decode by scanning only real entries, so out-of-range addresses read zero.
  always_comb begin
    rd_val1 = '0;
    rd_val2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        if (raddr1 == AW'(i)) rd_val1 = mem_q[i];
        if (raddr2 == AW'(i)) rd_val2 = mem_q[i];
      end
    end
    if ((BYPASS != 0) && wr_legal && (waddr == raddr1)) rd_val1 = wdata;
    if ((BYPASS != 0) && wr_legal && (waddr == raddr2)) rd_val2 = wdata;
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] rdata1_q;
    logic [WIDTH-1:0] rdata2_q;
    logic             rvalid1_q;
    logic             rvalid2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata1_q  <= '0;
        rdata2_q  <= '0;
        rvalid1_q <= 1'b0;
        rvalid2_q <= 1'b0;
      end else begin
        rvalid1_q <= re1;
        rvalid2_q <= re2;
        if (re1) rdata1_q <= rd_val1;
        if (re2) rdata2_q <= rd_val2;
      end
    end

    assign rdata1  = rdata1_q;
    assign rdata2  = rdata2_q;
    assign rvalid1 = rvalid1_q;
    assign rvalid2 = rvalid2_q;
  end else begin : g_comb_out
    assign rdata1  = rd_val1;
    assign rdata2  = rd_val2;
    assign rvalid1 = re1;
    assign rvalid2 = re2;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, number of registers (2..256, need not be a power of two).
REQ-003 SHALL provide parameter ZERO_REG, default 1, 1 = register 0 reads zero and ignores writes.
REQ-004 SHALL provide parameter REG_OUT, default 0, 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-005 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write data forwarded to a matching read.
REQ-006 SHALL derive localparam AW = max(1, ceil(log2(DEPTH))) as address width.
REQ-007 clk  input  1  single clock, rising edge active.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 we  input  1  write enable.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 re1, re2  input  1 each  read enables, ports 1/2.
REQ-013 raddr1, raddr2  input  AW each  read addresses.
REQ-014 rdata1, rdata2  output  WIDTH each  read data.
REQ-015 rvalid1, rvalid2  output  1 each  read-data-valid flags.

Function
REQ-016 Storage SHALL be DEPTH words of WIDTH bits.
REQ-017 Write legal = we && waddr < DEPTH && !(ZERO_REG && waddr == 0); legal write SHALL update mem[waddr] at rising clk; illegal writes SHALL change nothing.
REQ-018 Raw read value for port n SHALL be: 0 if raddrn >= DEPTH; 0 if ZERO_REG and raddrn == 0; else mem[raddrn].
REQ-019 With BYPASS=1, if write legal and waddr == raddrn, read value SHALL be wdata instead of raw value (write-first); BYPASS=0 SHALL return pre-write value.
REQ-020 REG_OUT=0: rdatan SHALL equal the read value combinationally regardless of ren; rvalidn SHALL equal ren combinationally.
REQ-021 REG_OUT=1: at rising clk with ren=1, rdatan SHALL load the read value and rvalidn SHALL go 1 the following cycle; with ren=0, rdatan SHALL hold and rvalidn SHALL go 0.
REQ-022 Both ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-023 Simultaneous write and read of the same address with BYPASS=1, REG_OUT=1: captured rdata SHALL be wdata, and mem SHALL hold wdata after the edge.
REQ-024 Back-to-back writes to the same address SHALL leave the last written value.
REQ-025 No combinational path SHALL exist from inputs to outputs when REG_OUT=1.

Reset
REQ-026 rst_n low SHALL, without waiting for clk, clear all DEPTH registers to 0.
REQ-027 rst_n low SHALL force rdata1, rdata2 to 0 and rvalid1, rvalid2 to 0 in REG_OUT=1 mode (REG_OUT=0 outputs follow REQ-020 with cleared storage).
REQ-028 Writes and read captures SHALL be suppressed while rst_n is low; first legal write SHALL take effect on the first rising clk with rst_n high.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight registered read; rvalidn SHALL be 0 the cycle reset releases.

Verification
REQ-030 Default params: write 0x1234 to r5, then read raddr1=5 -> rdata1=0x1234 same cycle, rvalid1=re1.
REQ-031 ZERO_REG=1: write 0xFFFF to r0, read r0 on both ports -> 0x0000; ZERO_REG=0 same stimulus -> 0xFFFF.
REQ-032 REG_OUT=1, BYPASS=1: we=1, waddr=3, wdata=0xA5A5, re1=1, raddr1=3 in same cycle (r3 previously 0x0001) -> next cycle rdata1=0xA5A5, rvalid1=1; BYPASS=0 -> rdata1=0x0001.
REQ-033 DEPTH=12, WIDTH=8: write 0x7E to addr 13 -> no register changes; read addr 13 -> 0x00; read addr 11 after writing 0x3C -> 0x3C.
REQ-034 REG_OUT=1: populate r1..r4, assert rst_n low asynchronously between edges with re1=1 pending -> rdata1=0, rvalid1=0 immediately; after release all reads return 0.
REQ-035 Randomised write/read stream on both ports (1000 cycles, all parameter corners) checked against reference model -> zero mismatches.
